// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console: register map, AXI response codes,
// default pass word, state encodings and the address decoder.
package mmio_pkg;

    localparam logic [31:0] ADDR_CONSOLE_TX    = 32'h1000_0000;
    localparam logic [31:0] ADDR_CONSOLE_STAT  = 32'h1000_0004;
    localparam logic [31:0] ADDR_TEST_STATUS   = 32'h2000_0000;
    localparam logic [31:0] ADDR_CYCLE         = 32'h2000_0004;

    localparam logic [1:0]  RESP_OKAY          = 2'b00;
    localparam logic [1:0]  RESP_SLVERR        = 2'b10;

    localparam logic [31:0] PASS_VALUE_DEFAULT = 32'd123456789;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CONSOLE_TX,
        REG_CONSOLE_STAT,
        REG_TEST_STATUS,
        REG_CYCLE
    } reg_sel_e;

    typedef enum logic {
        WR_COLLECT,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

    // Decode a word address (byte address bits [31:2]); byte lanes never matter.
    function automatic reg_sel_e decode_word(input logic [29:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word == ADDR_CONSOLE_TX[31:2])        sel = REG_CONSOLE_TX;
        else if (word == ADDR_CONSOLE_STAT[31:2]) sel = REG_CONSOLE_STAT;
        else if (word == ADDR_TEST_STATUS[31:2])  sel = REG_TEST_STATUS;
        else if (word == ADDR_CYCLE[31:2])        sel = REG_CYCLE;
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level. A push into a full FIFO is taken
// when a pop happens in the same cycle, so a streaming producer never stalls.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign head    = mem[rd_ptr];

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and level; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axi_mmio_console.sv
// AXI4-Lite MMIO slave for simulation harnesses: a console byte stream,
// a sticky pass/fail test status word and a free-running cycle counter.
module axi_mmio_console
    import mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_VALUE = PASS_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,

    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,

    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,

    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,

    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,

    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,

    output logic        tests_passed,
    output logic        tests_failed
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         wr_state, wr_state_nxt;
    rd_state_e         rd_state, rd_state_nxt;
    logic              ready_en;
    logic              aw_got, w_got;
    logic [29:0]       aw_word_q;
    logic [31:0]       w_data_q;
    logic              w_strb0_q;
    logic [31:0]       cycle_cnt;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    reg_sel_e          wr_sel, rd_sel;
    logic [1:0]        wr_resp;
    logic              tx_want, tx_stall, tx_push, tx_pop, wr_commit;
    logic [31:0]       rd_data_mux;
    logic [1:0]        rd_resp_mux;

    logic              fifo_empty, fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic [8:0]        level9;
    logic              unused_bits;

    assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], s_wstrb[3:1], level9[8]};

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;
    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;

    assign wr_sel    = decode_word(aw_word_q);
    assign wr_resp   = (wr_sel == REG_CONSOLE_TX || wr_sel == REG_TEST_STATUS) ? RESP_OKAY : RESP_SLVERR;
    assign tx_want   = (wr_sel == REG_CONSOLE_TX) && w_strb0_q;
    assign tx_pop    = tx_valid && tx_ready;
    // A console byte waits while the FIFO is full unless a pop frees a slot this cycle.
    assign tx_stall  = tx_want && fifo_full && !tx_pop;
    assign wr_commit = (wr_state == WR_COLLECT) && aw_got && w_got && !tx_stall;
    assign tx_push   = wr_commit && tx_want;

    assign tx_valid  = !fifo_empty;
    assign level9    = 9'(fifo_level);

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (tx_push),
        .push_data (w_data_q[7:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Hold all readies low for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (!resetn) ready_en <= 1'b0;
        else         ready_en <= 1'b1;
    end

    // Track which write halves are held; both clear together on the B handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (b_hs)       aw_got <= 1'b0;
            else if (aw_hs) aw_got <= 1'b1;
            if (b_hs)       w_got  <= 1'b0;
            else if (w_hs)  w_got  <= 1'b1;
        end
    end

    // Capture write address and data as each channel handshakes.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_word_q <= s_awaddr[31:2];
        if (w_hs) begin
            w_data_q  <= s_wdata;
            w_strb0_q <= s_wstrb[0];
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) wr_state <= WR_COLLECT;
        else         wr_state <= wr_state_nxt;
    end

    // Write FSM next state: respond once the write has taken effect.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_COLLECT: if (wr_commit) wr_state_nxt = WR_RESP;
            WR_RESP:    if (s_bready)  wr_state_nxt = WR_COLLECT;
            default:                   wr_state_nxt = WR_COLLECT;
        endcase
    end

    // Write FSM outputs: one write outstanding, response held until accepted.
    always_comb begin
        s_awready = ready_en && (wr_state == WR_COLLECT) && !aw_got;
        s_wready  = ready_en && (wr_state == WR_COLLECT) && !w_got;
        s_bvalid  = (wr_state == WR_RESP);
        s_bresp   = (wr_state == WR_RESP) ? wr_resp : RESP_OKAY;
    end

    // Sticky test status flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tests_passed <= 1'b0;
            tests_failed <= 1'b0;
        end else if (wr_commit && wr_sel == REG_TEST_STATUS) begin
            if (w_data_q == PASS_VALUE) tests_passed <= 1'b1;
            else                        tests_failed <= 1'b1;
        end
    end

    // Free-running cycle counter.
    always_ff @(posedge clk) begin
        if (!resetn) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 32'd1;
    end

    // Read data/response selection for the address presented on AR.
    always_comb begin
        rd_sel      = decode_word(s_araddr[31:2]);
        rd_data_mux = '0;
        rd_resp_mux = RESP_OKAY;
        case (rd_sel)
            REG_CONSOLE_STAT: rd_data_mux = {23'b0, fifo_full, level9[7:0]};
            REG_TEST_STATUS:  rd_data_mux = {30'b0, tests_failed, tests_passed};
            REG_CYCLE:        rd_data_mux = cycle_cnt;
            default:          rd_resp_mux = RESP_SLVERR;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) rd_state <= RD_IDLE;
        else         rd_state <= rd_state_nxt;
    end

    // Read FSM next state: one read in flight, returned the cycle after AR.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_state_nxt = RD_DATA;
            RD_DATA: if (r_hs)  rd_state_nxt = RD_IDLE;
            default:            rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        s_arready = ready_en && (rd_state == RD_IDLE);
        s_rvalid  = (rd_state == RD_DATA);
    end

    // Read data is frozen at AR acceptance so it stays stable until taken.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_rdata <= '0;
            s_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rdata <= rd_data_mux;
            s_rresp <= rd_resp_mux;
        end
    end

endmodule

// File: doc/axi_mmio_console.md
AXI_MMIO_CONSOLE -- requirements
Module: axi_mmio_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, console TX FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter PASS_VALUE, default 32'd123456789, test-status word that signals pass.
REQ-003 SHALL have ports clk input 1 (clock) and resetn input 1 (reset, synchronous, active-low).
REQ-004 SHALL have AXI4-Lite write-address ports: s_awvalid in 1, s_awready out 1, s_awaddr in 32.
REQ-005 SHALL have AXI4-Lite write-data ports: s_wvalid in 1, s_wready out 1, s_wdata in 32, s_wstrb in 4.
REQ-006 SHALL have AXI4-Lite write-response ports: s_bvalid out 1, s_bready in 1, s_bresp out 2.
REQ-007 SHALL have AXI4-Lite read-address ports: s_arvalid in 1, s_arready out 1, s_araddr in 32.
REQ-008 SHALL have AXI4-Lite read-data ports: s_rvalid out 1, s_rready in 1, s_rdata out 32, s_rresp out 2.
REQ-009 SHALL have console ports: tx_valid out 1, tx_ready in 1, tx_data out 8 (byte stream to host).
REQ-010 SHALL have status outputs tests_passed out 1 and tests_failed out 1 (sticky).

Function
REQ-011 SHALL decode the register map: 0x1000_0000 CONSOLE_TX (W), 0x1000_0004 CONSOLE_STAT (R), 0x2000_0000 TEST_STATUS (W/R), 0x2000_0004 CYCLE (R).
REQ-012 SHALL accept AW and W independently, in either order or the same cycle, each latched on valid&&ready.
REQ-013 SHALL deassert awready/wready once the respective channel is latched, until its B handshake completes.
REQ-014 SHALL assert bvalid the cycle after both AW and W are latched, hold it and bresp stable until bready, and allow one outstanding write only.
REQ-015 SHALL, on a CONSOLE_TX write with wstrb[0]=1, push wdata[7:0] into the FIFO, delaying bvalid while the FIFO is full (no drop, no overwrite).
REQ-016 SHALL, on a TEST_STATUS write, set tests_passed if wdata==PASS_VALUE, else set tests_failed; both flags stay set until reset.
REQ-017 SHALL respond to writes to unmapped or read-only addresses with bresp=2'b10 (SLVERR) and no side effect; mapped writes return 2'b00.
REQ-018 SHALL assert arready for one cycle per accepted read, then rvalid the next cycle, holding rdata/rresp stable until rready.
REQ-019 SHALL return CONSOLE_STAT as {23'b0, full, level[7:0]}, TEST_STATUS as {30'b0, tests_failed, tests_passed}, CYCLE as the free-running counter value at AR acceptance.
REQ-020 SHALL return rdata=0, rresp=2'b10 for unmapped or write-only read addresses.
REQ-021 SHALL ignore s_awaddr/s_araddr bits [1:0] for decode.
REQ-022 SHALL present the FIFO head on tx_data with tx_valid=!empty, popping on tx_valid&&tx_ready.
REQ-023 SHALL permit push and pop in the same cycle when full, with level unchanged and no stall.
REQ-024 SHALL keep a 32-bit CYCLE counter incrementing every clk out of reset, wrapping 0xFFFF_FFFF to 0.
REQ-025 SHALL serve reads and writes concurrently with no mutual blocking.

Reset
REQ-026 SHALL, while resetn=0 at a clk edge, clear all ready/valid outputs, bresp, rresp, rdata, tests_passed, tests_failed, CYCLE, and the FIFO pointers/level.
REQ-027 SHALL abandon any in-flight AXI transaction on reset, with no B/R response issued for it afterwards.

Structure
REQ-028 SHALL place register offsets, AXI response codes and the default PASS_VALUE in shared package mmio_pkg.
REQ-029 SHALL implement the console buffer as a sub-module sync_fifo (parameterised width/depth, level and full outputs).

Verification
REQ-030 SHALL cover AW one cycle before W, W first, then both same-cycle; write 0x41 to 0x1000_0000 -> bresp=0, tx_data=0x41.
REQ-031 SHALL cover tx_ready=0 with 17 writes of 0x00..0x10 -> 17th bvalid withheld until one pop; output order 0x00..0x10.
REQ-032 SHALL cover TEST_STATUS write 123456789 -> tests_passed=1; then write 5 -> tests_failed=1, passed stays 1; read TEST_STATUS returns 3.
REQ-033 SHALL cover read of 0x3000_0000 -> rresp=2'b10, rdata=0; write of 0x1000_0004 -> bresp=2'b10, FIFO level unchanged.
REQ-034 SHALL cover rready held low 5 cycles on a CYCLE read -> rdata constant, arready stays 0 for a second pending AR.
REQ-035 SHALL cover resetn pulsed low while bvalid is pending -> bvalid=0 next cycle, level=0, no later response.
